stack_display_driver: RTL
=========================

Name: stack_display_driver

Overview:
- Downstream consumer of the processor top level's top_of_stack and second_of_stack outputs.
- Drives a 4-digit multiplexed common-anode 7-segment display on the board.
- Selects which stack word is shown, freezes the shown value on a debounced push button, and scans digits from a prescaled refresh counter.
- Runs on the fast board clock CLK, not the processor's divided clock.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit before advancing to the next digit (>=2).
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required before the debounced button level changes (>=2).

Ports:
- CLK  input  1  board clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- top_of_stack  input  16  processor stack top.
- second_of_stack  input  16  processor stack second entry.
- show_second  input  1  raw switch; 1 selects second_of_stack, 0 selects top_of_stack.
- hold_btn  input  1  raw push button, active-high, bouncy.
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low one-hot; an[0] = rightmost digit.
- held  output  1  1 while the display is frozen.

Behaviour:
- Synchronizers: show_second and hold_btn each pass through a 2-flop synchronizer, reset to 0.
- Debouncer:
  - Counter compares the synchronized button against the debounced level db.
  - While they differ, the counter increments; when they are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, db flips and the counter clears.
  - db resets to 0.
- Hold toggle: a rising edge of db (db=1, db_prev=0) toggles held. Only one toggle per press; the release edge has no effect.
- Snapshot register, 16 bits:
  - While held=0, loads (sync show_second ? second_of_stack : top_of_stack) every cycle.
  - While held=1, holds its value.
  - On the toggle edge that sets held, snapshot keeps the value loaded that same edge.
  - Switching show_second while held has no effect until release.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cycle it equals REFRESH_DIV-1, digit index (2 bits) increments mod 4 (3 wraps to 0).
- Output register:
  - an, seg and dp are registered from the current digit index and snapshot, so outputs lag the index by 1 cycle.
  - an = ~(4'b0001 << digit).
  - Nibble = snapshot[4*digit+3 : 4*digit].
  - seg uses standard active-low hex encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - dp = 0 only when digit==0 and held==1; otherwise 1. This marks a frozen display.
- Reset values (asynchronous, immediate while reset=0):
  - Prescaler 0, digit 0, debounce counter 0, db 0, held 0, snapshot 0.
  - an=4'b1110, seg=7'b1000000, dp=1.
- Reset asserted mid-press or mid-scan returns all of the above immediately. After release, a still-held button must be re-debounced, and the rising db edge then toggles held to 1.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES samples resets the counter and produces no db change.
- No blanking: exactly one anode is active at all times after reset.

Test Plan:
- Use REFRESH_DIV=4, DEBOUNCE_CYCLES=8 for all scenarios.
- Reset/scan: hold reset=0 -> an=1110, seg=1000000, dp=1, held=0. Release with top_of_stack=16'h1234 -> within 3 cycles seg=0011001 (4) on an=1110. After every 4 cycles the anode advances: 1101 shows 3 (0110000), 1011 shows 2, 0111 shows 1. After an=0111 the scan wraps back to 1110.
- Select: top=16'hABCD, second=16'h00EF, show_second=1 -> after synchronizer + 1 cycle, digit0 shows F (0001110) and digit3 shows 0. Set show_second=0 -> digit0 shows d (0100001).
- Debounce/hold: toggle hold_btn 0/1 every 3 cycles for 30 cycles -> held stays 0. Then hold it at 1 for 12 cycles -> held=1 and dp=0 on digit0. Change top_of_stack to 16'hFFFF -> displayed nibbles unchanged.
- Release/toggle: release the button for 12 cycles -> held stays 1. Press again for 12 cycles -> held=0, and the display tracks the live top_of_stack within 2 cycles.
- Async reset mid-hold: with held=1, pulse reset=0 for 1 cycle between clock edges -> held=0, an=1110, seg=1000000 immediately, without waiting for a CLK edge.
- Wrap boundary: snapshot=16'h8000 -> digit3 shows 8 (0000000) and digits 0-2 show 0. Observe 100 consecutive cycles -> the anode sequence is periodic at 16 cycles with no gaps or double-active anodes.

Source files
------------

// File: rtl/stack_display_driver.sv
// Shows the processor's top or second stack word on a 4-digit multiplexed
// common-anode 7-segment display. A debounced push button freezes the shown value.
module stack_display_driver #(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] top_of_stack,
  input  logic [15:0] second_of_stack,
  input  logic        show_second,
  input  logic        hold_btn,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        held
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sel_meta, r_sel_sync;
  logic          r_btn_meta, r_btn_sync;
  logic [DW-1:0] r_db_cnt;
  logic          r_db, r_db_prev;
  logic          r_held;
  logic [15:0]   r_snap;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_digit;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_an;

  logic          w_toggle;
  logic [3:0]    w_nibble;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'b1000000;
      4'h1: f_hex = 7'b1111001;
      4'h2: f_hex = 7'b0100100;
      4'h3: f_hex = 7'b0110000;
      4'h4: f_hex = 7'b0011001;
      4'h5: f_hex = 7'b0010010;
      4'h6: f_hex = 7'b0000010;
      4'h7: f_hex = 7'b1111000;
      4'h8: f_hex = 7'b0000000;
      4'h9: f_hex = 7'b0010000;
      4'hA: f_hex = 7'b0001000;
      4'hB: f_hex = 7'b0000011;
      4'hC: f_hex = 7'b1000110;
      4'hD: f_hex = 7'b0100001;
      4'hE: f_hex = 7'b0000110;
      default: f_hex = 7'b0001110;
    endcase
  endfunction

  assign w_toggle = r_db & ~r_db_prev;
  assign w_nibble = r_snap[{r_digit, 2'b00} +: 4];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_sel_meta <= 1'b0;
      r_sel_sync <= 1'b0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_sel_meta <= show_second;
      r_sel_sync <= r_sel_meta;
      r_btn_meta <= hold_btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Any sample that agrees with the current level restarts the stability count.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_db_cnt  <= '0;
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
    end else begin
      r_db_prev <= r_db;
      if (r_btn_sync != r_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_db     <= ~r_db;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Snapshot still loads on the edge that freezes, so the frozen value is the latest one.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_held <= 1'b0;
      r_snap <= 16'h0000;
    end else begin
      if (w_toggle) r_held <= ~r_held;
      if (!r_held) r_snap <= r_sel_sync ? second_of_stack : top_of_stack;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_digit <= 2'd0;
    end else if (r_pre == PRE_LAST) begin
      r_pre   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= f_hex(w_nibble);
      r_dp  <= ~((r_digit == 2'd0) & r_held);
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign held = r_held;

endmodule
